// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and FSM state type for the SHA-256 message padder.
//   BLOCK_WORDS  32-bit words per 512-bit block
//   LEN_FIELD_W  width of the trailing message-length field
//   PAD_BYTE     first padding byte appended after the message
package sha256_pkg;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned LEN_FIELD_W = 64;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    EMIT,
    WAIT,
    PADX
  } pad_state_t;
endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: combinational last-word formatter.
//   data   big-endian message word, first byte in [31:24]
//   bytes  number of valid leading bytes (0..4; values above 4 act as 4)
//   word   valid bytes kept, PAD_BYTE at byte position 'bytes', remaining bytes zero
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  bytes,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (3'(b) < bytes) begin
        word[31 - 8*b -: 8] = data[31 - 8*b -: 8];
      end else if (3'(b) == bytes) begin
        word[31 - 8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: assembles a 32-bit big-endian word stream into 512-bit blocks
// with FIPS 180-4 padding (0x80, zero fill, 64-bit bit length) for the SHA-256 core.
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   word stream handshake
//   in_last/in_bytes            final word marker and its valid byte count (0..4)
//   block_out                   assembled block, word 0 in [511:480]
//   start_block/block_valid     one-cycle pulse per block issued to the core
//   core_busy/comp_done         core status; a new block waits for comp_done
//   first_block                 block_out holds the first block of a message
//   msg_done                    pulse after the final block completes
// Optional: define SHA256_PAD_BLKCNT_EN to add blk_cnt[15:0], a saturating
// count of blocks issued for the current message.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         in_ready,
  output logic [511:0] block_out,
  output logic         start_block,
  output logic         block_valid,
  input  logic         core_busy,
  input  logic         comp_done,
  output logic         first_block,
`ifdef SHA256_PAD_BLKCNT_EN
  output logic         msg_done,
  output logic [15:0]  blk_cnt
`else
  output logic         msg_done
`endif
);

  pad_state_t       state_q;
  logic [31:0]      words_q [BLOCK_WORDS];
  logic [3:0]       idx_q;
  logic [LEN_W-1:0] len_q;
  logic             pad_extra_q;
  logic             p16_q;
  logic             final_q;

  logic                   take;
  logic [3:0]             bidx;
  logic [LEN_W-1:0]       blen;
  logic [2:0]             nb;
  logic                   full_last;
  logic [4:0]             p;
  logic [5:0]             add;
  logic [LEN_W-1:0]       new_len;
  logic [LEN_FIELD_W-1:0] len_field_new;
  logic [LEN_FIELD_W-1:0] len_field_q;
  logic [31:0]            pad_word;

  // in_ready is only high in IDLE/FILL, so take implies one of those states.
  // A word taken in IDLE sees a cleared index and length in the same cycle.
  assign take          = in_valid & in_ready;
  assign bidx          = (state_q == IDLE) ? '0 : idx_q;
  assign blen          = (state_q == IDLE) ? '0 : len_q;
  assign nb            = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign full_last     = (nb == 3'd4);
  // p: word index holding the 0x80 byte (16 means it spills into a fresh block)
  assign p             = {1'b0, bidx} + {4'b0, full_last};
  assign add           = in_last ? {nb, 3'b000} : 6'd32;
  assign new_len       = blen + LEN_W'(add);
  assign len_field_new = LEN_FIELD_W'(new_len);
  assign len_field_q   = LEN_FIELD_W'(len_q);

  sha256_pad_word u_pad_word (
    .data  (in_data),
    .bytes (nb),
    .word  (pad_word)
  );

  always_comb begin
    block_out = '0;
    for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
      block_out[511 - 32*i -: 32] = words_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready    <= 1'b0;
      start_block <= 1'b0;
      block_valid <= 1'b0;
      msg_done    <= 1'b0;
      first_block <= 1'b0;
      idx_q       <= '0;
      len_q       <= '0;
      pad_extra_q <= 1'b0;
      p16_q       <= 1'b0;
      final_q     <= 1'b0;
      for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else begin
      start_block <= 1'b0;
      block_valid <= 1'b0;
      msg_done    <= 1'b0;
      unique case (state_q)
        IDLE, FILL: begin
          if (state_q == IDLE) begin
            first_block <= 1'b1;
            idx_q       <= '0;
            len_q       <= '0;
            in_ready    <= 1'b1;
          end
          if (take) begin
            len_q   <= new_len;
            state_q <= FILL;
            if (!in_last) begin
              words_q[bidx] <= in_data;
              idx_q         <= bidx + 4'd1;
              if (bidx == 4'(BLOCK_WORDS - 1)) begin
                final_q     <= 1'b0;
                pad_extra_q <= 1'b0;
                p16_q       <= 1'b0;
                in_ready    <= 1'b0;
                state_q     <= EMIT;
              end
            end else begin
              for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                if (5'(i) == {1'b0, bidx}) begin
                  words_q[i] <= pad_word;
                end else if (5'(i) == p) begin
                  words_q[i] <= {PAD_BYTE, 24'h0};
                end else if (5'(i) > p) begin
                  words_q[i] <= '0;
                end
              end
              if (p <= 5'd13) begin
                words_q[BLOCK_WORDS-2] <= len_field_new[63:32];
                words_q[BLOCK_WORDS-1] <= len_field_new[31:0];
              end
              final_q     <= (p <= 5'd13);
              pad_extra_q <= (p >= 5'd14);
              p16_q       <= (p == 5'd16);
              in_ready    <= 1'b0;
              state_q     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (!core_busy) begin
            start_block <= 1'b1;
            block_valid <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (comp_done) begin
            first_block <= 1'b0;
            if (pad_extra_q) begin
              state_q <= PADX;
            end else if (final_q) begin
              msg_done <= 1'b1;
              in_ready <= 1'b1;
              state_q  <= IDLE;
            end else begin
              idx_q    <= '0;
              in_ready <= 1'b1;
              state_q  <= FILL;
            end
          end
        end
        PADX: begin
          for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
            words_q[i] <= '0;
          end
          if (p16_q) begin
            words_q[0] <= {PAD_BYTE, 24'h0};
          end
          words_q[BLOCK_WORDS-2] <= len_field_q[63:32];
          words_q[BLOCK_WORDS-1] <= len_field_q[31:0];
          pad_extra_q <= 1'b0;
          final_q     <= 1'b1;
          state_q     <= EMIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SHA256_PAD_BLKCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (state_q == WAIT && comp_done && !pad_extra_q && final_q) begin
      blk_cnt <= '0;
    end else if (state_q == EMIT && !core_busy && blk_cnt != '1) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed bench for sha256_padder. Expected blocks come from a
// byte-level FIPS 180-4 padding model; literal block values pin the model and DUT.
`timescale 1ns/1ps
module tb_sha256_padder;

  typedef byte unsigned  bq_t[$];
  typedef logic [511:0]  blk_q_t[$];

  logic         clk;
  logic         rst_n;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         in_ready;
  logic [511:0] block_out;
  logic         start_block;
  logic         block_valid;
  logic         core_busy;
  logic         comp_done;
  logic         first_block;
  logic         msg_done;
  logic         core_cd;
  logic         spur_cd;
`ifdef SHA256_PAD_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  assign comp_done = core_cd | spur_cd;

  sha256_padder #(.LEN_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .in_ready    (in_ready),
    .block_out   (block_out),
    .start_block (start_block),
    .block_valid (block_valid),
    .core_busy   (core_busy),
    .comp_done   (comp_done),
    .first_block (first_block),
`ifdef SHA256_PAD_BLKCNT_EN
    .msg_done    (msg_done),
    .blk_cnt     (blk_cnt)
`else
    .msg_done    (msg_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_pass = 0;
  int unsigned  n_total = 0;
  int unsigned  n_md = 0;
  logic [511:0] exp_q[$];
  bit           exp_first_q[$];
  bit           exp_final_q[$];
  logic [511:0] got_q[$];
  bit           got_first_q[$];
  bit           awaiting = 1'b0;
  bit           cur_final = 1'b0;
  bit           md_exp = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Byte-level padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
  task automatic model_pad(input bq_t msg, output blk_q_t blks);
    bq_t          pm;
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nblk;
    pm   = msg;
    bits = 64'(msg.size()) * 64'd8;
    pm.push_back(8'h80);
    while ((pm.size() % 64) != 56) pm.push_back(8'h00);
    for (int k = 7; k >= 0; k--) pm.push_back(bits[8*k +: 8]);
    nblk = pm.size() / 64;
    blks.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = pm[b*64 + j];
      blks.push_back(blk);
    end
  endtask

  task automatic model_load(input bq_t msg);
    blk_q_t blks;
    model_pad(msg, blks);
    for (int b = 0; b < blks.size(); b++) begin
      exp_q.push_back(blks[b]);
      exp_first_q.push_back(b == 0);
      exp_final_q.push_back(b == blks.size() - 1);
    end
  endtask

  function automatic bq_t gen_msg(input int n, input int seed);
    bq_t m;
    for (int j = 0; j < n; j++) m.push_back(8'((j * 13 + seed) & 255));
    return m;
  endfunction

  // Core stand-in: comp_done three cycles after each start_block, changed just after posedge.
  initial begin
    core_cd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && start_block) begin
        repeat (3) @(posedge clk);
        #1 core_cd = 1'b1;
        @(posedge clk);
        #1 core_cd = 1'b0;
      end
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    logic [511:0] e;
    bit           f;
    bit           fin;
    if (rst_n !== 1'b1) begin
      awaiting = 1'b0;
      md_exp   = 1'b0;
    end else begin
      chk("msg_done", msg_done, md_exp);
      if (msg_done) n_md++;
      md_exp = 1'b0;
      if (awaiting && comp_done) begin
        awaiting = 1'b0;
        md_exp   = cur_final;
      end
      if (start_block) begin
        chk("block_valid", block_valid, 1);
        if (exp_q.size() == 0) begin
          chk("spurious_start", start_block, 0);
        end else begin
          e   = exp_q.pop_front();
          f   = exp_first_q.pop_front();
          fin = exp_final_q.pop_front();
          chk("block_out", block_out, e);
          chk("first_block", first_block, f);
          cur_final = fin;
        end
        awaiting = 1'b1;
        got_q.push_back(block_out);
        got_first_q.push_back(first_block);
      end else begin
        chk("block_valid_idle", block_valid, 0);
      end
      if (awaiting) chk("in_ready_wait", in_ready, 0);
    end
  end

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
    int unsigned t = 0;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input bit bp, input int max_words);
    int unsigned L;
    int unsigned nw;
    logic [31:0] w;
    bit          last;
    L  = msg.size();
    nw = (L == 0) ? 1 : (L + 3) / 4;
    for (int unsigned i = 0; i < nw && int'(i) < max_words; i++) begin
      w = 32'hA5A5A5A5;
      for (int unsigned b = 0; b < 4; b++)
        if (4*i + b < L) w[31 - 8*b -: 8] = msg[4*i + b];
      last = (i == nw - 1);
      if (last && bp) core_busy = 1'b1;
      send_word(w, last, last ? 3'(L - 4*i) : 3'd4);
    end
  endtask

  task automatic run_msg(input bq_t msg, input bit bp);
    int unsigned  md0;
    int unsigned  t;
    logic [511:0] hold;
    got_q.delete();
    got_first_q.delete();
    model_load(msg);
    md0 = n_md;
    send_msg(msg, bp, 1000);
    if (bp) begin
      hold = block_out;
      repeat (10) begin
        @(negedge clk);
        chk("bp_no_start", start_block, 0);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_block_stable", block_out, hold);
      end
      core_busy = 1'b0;
    end
    @(negedge clk);
    chk("start_latency", start_block, 1);
    t = 0;
    while (n_md == md0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("msg_done_seen", n_md - md0, 1);
    chk("model_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t          m;
    blk_q_t       pb;
    logic [511:0] blk;
    int           lens [7] = '{55, 57, 61, 63, 4, 100, 128};

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_bytes  = '0;
    core_busy = 1'b0;
    spur_cd   = 1'b0;

    // Model pins
    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    model_pad(m, pb);
    chk("pin_abc_count", pb.size(), 1);
    chk("pin_abc_block", pb[0], {32'h61626380, 448'h0, 32'h00000018});
    model_pad(gen_msg(64, 5), pb);
    chk("pin_m64_count", pb.size(), 2);
    chk("pin_m64_block2", pb[1], {32'h80000000, 448'h0, 32'h00000200});

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", start_block, 0);
    chk("rst_valid", block_valid, 0);
    chk("rst_msg_done", msg_done, 0);
    chk("rst_first", first_block, 0);
    chk("rst_block", block_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_first", first_block, 1);

    // "abc"
    run_msg(m, 1'b0);
    chk("abc_nblk", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("abc_block", got_q[0], {32'h61626380, 448'h0, 32'h00000018});
      chk("abc_first", got_first_q[0], 1);
    end

    // Empty message
    m.delete();
    run_msg(m, 1'b0);
    chk("empty_nblk", got_q.size(), 1);
    if (got_q.size() >= 1) chk("empty_block", got_q[0], {32'h80000000, 480'h0});

    // 56 bytes: padding spills into a second block
    run_msg(gen_msg(56, 1), 1'b0);
    chk("m56_nblk", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      blk = got_q[0];
      chk("m56_b1_w14", blk[63:32], 32'h80000000);
      chk("m56_b1_w15", blk[31:0], 32'h0);
      chk("m56_b2", got_q[1], {480'h0, 32'h000001C0});
      chk("m56_b2_first", got_first_q[1], 0);
    end

    // 64 bytes: 0x80 opens the second block
    run_msg(gen_msg(64, 2), 1'b0);
    chk("m64_nblk", got_q.size(), 2);
    if (got_q.size() >= 2) chk("m64_b2", got_q[1], {32'h80000000, 448'h0, 32'h00000200});

    // Further lengths around the block boundaries
    foreach (lens[i]) run_msg(gen_msg(lens[i], 3 + i), 1'b0);

    // Backpressure at EMIT
    run_msg(gen_msg(9, 40), 1'b1);

    // comp_done outside WAIT is ignored
    @(posedge clk); #1 spur_cd = 1'b1;
    @(posedge clk); #1 spur_cd = 1'b0;
    repeat (4) @(negedge clk);
    chk("spur_in_ready", in_ready, 1);

    // Reset mid-message at word index 7
    send_msg(gen_msg(64, 9), 1'b0, 7);
    @(posedge clk); #2 rst_n = 1'b0;
    exp_q.delete();
    exp_first_q.delete();
    exp_final_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_block", block_out, 0);
    chk("mid_rst_start", start_block, 0);
    chk("mid_rst_msg_done", msg_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    m.delete();
    m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
    run_msg(m, 1'b0);
    chk("post_rst_abc_nblk", got_q.size(), 1);
    if (got_q.size() >= 1) chk("post_rst_abc", got_q[0], {32'h61626380, 448'h0, 32'h00000018});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
